// File: rtl/bcd_encoder.sv
// bcd_encoder: iterative double-dabble conversion of a 16-bit unsigned value
// into four packed BCD digits for the 7-segment debug display. The block
// accepts one value via a valid/ready handshake, runs one shift per clock,
// then loads the result with a leading-zero blank mask and an overflow flag.
module bcd_encoder #(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] in_value,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] bcd,
    output logic [3:0]  blank,
    output logic        overflow,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [15:0] binShift_q, binShift_d;
    logic [19:0] scratch_q, scratch_d;
    logic [3:0]  iterCount_q, iterCount_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  blank_q, blank_d;
    logic        overflow_q, overflow_d;
    logic        done_q, done_d;

    logic [19:0] scratchAdjusted;
    logic        loadOverflow;
    logic [15:0] loadBcd;

    // State register; reset forces IDLE regardless of where a conversion is.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, run 16 shifts, then a single load cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (iterCount_q == 4'd15) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: ready only while idle and not being held in reset.
    always_comb begin
        in_ready = (state_q == IDLE) && !reset;
    end

    // Per-digit add-3 correction; digits never carry into each other.
    always_comb begin
        scratchAdjusted = scratch_q;
        for (int i = 0; i < 5; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratchAdjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Result formatting: the fifth digit flags overflow, saturation picks 9999.
    always_comb begin
        loadOverflow = (scratch_q[19:16] != 4'd0);
        if (loadOverflow && SATURATE) begin
            loadBcd = 16'h9999;
        end else begin
            loadBcd = scratch_q[15:0];
        end
    end

    // Datapath next values: capture, shift, or publish depending on state.
    always_comb begin
        binShift_d  = binShift_q;
        scratch_d   = scratch_q;
        iterCount_d = iterCount_q;
        bcd_d       = bcd_q;
        blank_d     = blank_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    binShift_d  = in_value;
                    scratch_d   = 20'd0;
                    iterCount_d = 4'd0;
                end
            end
            SHIFT: begin
                scratch_d   = {scratchAdjusted[18:0], binShift_q[15]};
                binShift_d  = {binShift_q[14:0], 1'b0};
                iterCount_d = iterCount_q + 4'd1;
            end
            LOAD: begin
                overflow_d = loadOverflow;
                bcd_d      = loadBcd;
                blank_d[3] = (loadBcd[15:12] == 4'd0);
                blank_d[2] = blank_d[3] && (loadBcd[11:8] == 4'd0);
                blank_d[1] = blank_d[2] && (loadBcd[7:4] == 4'd0);
                blank_d[0] = 1'b0;
                done_d     = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; outputs hold between loads so the display stays stable.
    always_ff @(posedge clock) begin
        if (reset) begin
            binShift_q  <= 16'd0;
            scratch_q   <= 20'd0;
            iterCount_q <= 4'd0;
            bcd_q       <= 16'h0000;
            blank_q     <= 4'b1110;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            binShift_q  <= binShift_d;
            scratch_q   <= scratch_d;
            iterCount_q <= iterCount_d;
            bcd_q       <= bcd_d;
            blank_q     <= blank_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    assign bcd      = bcd_q;
    assign blank    = blank_q;
    assign overflow = overflow_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bcd_encoder.sv
// tb_bcd_encoder: drives a saturating and a wrapping instance with the same
// stimulus and compares both against a decimal arithmetic reference model.
module tb_bcd_encoder;

    logic        clock;
    logic        reset;
    logic [15:0] in_value;
    logic        in_valid;

    logic        readyS, readyW;
    logic [15:0] bcdS, bcdW;
    logic [3:0]  blankS, blankW;
    logic        ovS, ovW;
    logic        doneS, doneW;

    int checks;
    int failures;

    bcd_encoder #(.SATURATE(1'b1)) dutSat (
        .clock    (clock),
        .reset    (reset),
        .in_value (in_value),
        .in_valid (in_valid),
        .in_ready (readyS),
        .bcd      (bcdS),
        .blank    (blankS),
        .overflow (ovS),
        .done     (doneS)
    );

    bcd_encoder #(.SATURATE(1'b0)) dutWrap (
        .clock    (clock),
        .reset    (reset),
        .in_value (in_value),
        .in_valid (in_valid),
        .in_ready (readyW),
        .bcd      (bcdW),
        .blank    (blankW),
        .overflow (ovW),
        .done     (doneW)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference: decimal value shown on the display after saturation/wrap.
    function automatic int refShown(input int v, input bit sat);
        if (v > 9999) begin
            return sat ? 9999 : (v % 10000);
        end
        return v;
    endfunction

    function automatic logic [15:0] refBcd(input int v, input bit sat);
        int d;
        d = refShown(v, sat);
        return {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
    endfunction

    function automatic logic [3:0] refBlank(input int v, input bit sat);
        int d;
        d = refShown(v, sat);
        return {1'(d < 1000), 1'(d < 100), 1'(d < 10), 1'b0};
    endfunction

    // Presents one value at the next edge, then watches for done (bounded).
    task automatic runConversion(input logic [15:0] v, output int latency,
                                 output int readyHigh);
        in_value = v;
        in_valid = 1'b1;
        @(posedge clock);
        #2;
        in_valid  = 1'b0;
        in_value  = 16'($urandom);
        latency   = -1;
        readyHigh = 0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clock);
            if (doneS) begin
                latency = k;
                break;
            end
            if (readyS) readyHigh++;
        end
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_value = 16'd0;
        repeat (2) @(negedge clock);
        checks++; if (bcdS !== 16'h0000) begin failures++; $display("[TB] FAIL reset_bcd got=%h want=0000", bcdS); end
        checks++; if (blankS !== 4'b1110) begin failures++; $display("[TB] FAIL reset_blank got=%b want=1110", blankS); end
        checks++; if (ovS !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%b want=0", ovS); end
        checks++; if (doneS !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", doneS); end
        checks++; if (readyS !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b want=0", readyS); end
        // Reset and valid on the same edge: nothing must be accepted.
        in_value = 16'd77;
        in_valid = 1'b1;
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        checks++; if (readyS !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_reset got=%b want=1", readyS); end
        begin
            int pulses;
            pulses = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clock);
                if (doneS) pulses++;
            end
            checks++; if (pulses !== 0) begin failures++; $display("[TB] FAIL reset_wins_accept got=%0d pulses want=0", pulses); end
        end
    endtask

    task automatic test_basic;
        int lat, rdy;
        runConversion(16'd1234, lat, rdy);
        checks++; if (lat !== 17) begin failures++; $display("[TB] FAIL basic_latency got=%0d want=17", lat); end
        checks++; if (rdy !== 0) begin failures++; $display("[TB] FAIL basic_ready_busy got=%0d cycles high want=0", rdy); end
        checks++; if (bcdS !== 16'h1234) begin failures++; $display("[TB] FAIL basic_bcd got=%h want=1234", bcdS); end
        checks++; if (blankS !== 4'b0000) begin failures++; $display("[TB] FAIL basic_blank got=%b want=0000", blankS); end
        checks++; if (ovS !== 1'b0) begin failures++; $display("[TB] FAIL basic_overflow got=%b want=0", ovS); end
        checks++; if (readyS !== 1'b1) begin failures++; $display("[TB] FAIL basic_ready_done got=%b want=1", readyS); end
        @(negedge clock);
        checks++; if (doneS !== 1'b0) begin failures++; $display("[TB] FAIL basic_done_width got=%b want=0", doneS); end
    endtask

    task automatic test_leading_zeros;
        logic [15:0] vals [4]  = '{16'd0, 16'd7, 16'd105, 16'd9999};
        logic [15:0] wantB [4] = '{16'h0000, 16'h0007, 16'h0105, 16'h9999};
        logic [3:0]  wantK [4] = '{4'b1110, 4'b1110, 4'b1000, 4'b0000};
        int lat, rdy;
        for (int i = 0; i < 4; i++) begin
            runConversion(vals[i], lat, rdy);
            checks++; if (bcdS !== wantB[i]) begin failures++; $display("[TB] FAIL lz_bcd[%0d] got=%h want=%h", vals[i], bcdS, wantB[i]); end
            checks++; if (blankS !== wantK[i]) begin failures++; $display("[TB] FAIL lz_blank[%0d] got=%b want=%b", vals[i], blankS, wantK[i]); end
            checks++; if (ovS !== 1'b0) begin failures++; $display("[TB] FAIL lz_overflow[%0d] got=%b want=0", vals[i], ovS); end
        end
    endtask

    task automatic test_overflow;
        int lat, rdy;
        runConversion(16'd10000, lat, rdy);
        checks++; if (bcdS !== 16'h9999) begin failures++; $display("[TB] FAIL ovf_sat_10000 got=%h want=9999", bcdS); end
        checks++; if (ovS !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sat_flag_10000 got=%b want=1", ovS); end
        checks++; if (bcdW !== 16'h0000) begin failures++; $display("[TB] FAIL ovf_wrap_10000 got=%h want=0000", bcdW); end
        checks++; if (ovW !== 1'b1) begin failures++; $display("[TB] FAIL ovf_wrap_flag_10000 got=%b want=1", ovW); end
        checks++; if (blankW !== 4'b1110) begin failures++; $display("[TB] FAIL ovf_wrap_blank_10000 got=%b want=1110", blankW); end
        runConversion(16'd65535, lat, rdy);
        checks++; if (bcdS !== 16'h9999) begin failures++; $display("[TB] FAIL ovf_sat_65535 got=%h want=9999", bcdS); end
        checks++; if (ovS !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sat_flag_65535 got=%b want=1", ovS); end
        checks++; if (blankS !== 4'b0000) begin failures++; $display("[TB] FAIL ovf_sat_blank_65535 got=%b want=0000", blankS); end
        checks++; if (bcdW !== 16'h5535) begin failures++; $display("[TB] FAIL ovf_wrap_65535 got=%h want=5535", bcdW); end
        checks++; if (ovW !== 1'b1) begin failures++; $display("[TB] FAIL ovf_wrap_flag_65535 got=%b want=1", ovW); end
        checks++; if (blankW !== 4'b0000) begin failures++; $display("[TB] FAIL ovf_wrap_blank_65535 got=%b want=0000", blankW); end
    endtask

    task automatic test_random;
        int lat, rdy;
        logic [15:0] v;
        for (int i = 0; i < 24; i++) begin
            case (i % 3)
                0: v = 16'($urandom_range(0, 9999));
                1: v = 16'($urandom_range(9990, 10010));
                default: v = 16'($urandom);
            endcase
            runConversion(v, lat, rdy);
            checks++; if (lat !== 17) begin failures++; $display("[TB] FAIL rand_latency[%0d] got=%0d want=17", v, lat); end
            checks++; if (bcdS !== refBcd(int'(v), 1'b1)) begin failures++; $display("[TB] FAIL rand_sat_bcd[%0d] got=%h want=%h", v, bcdS, refBcd(int'(v), 1'b1)); end
            checks++; if (blankS !== refBlank(int'(v), 1'b1)) begin failures++; $display("[TB] FAIL rand_sat_blank[%0d] got=%b want=%b", v, blankS, refBlank(int'(v), 1'b1)); end
            checks++; if (bcdW !== refBcd(int'(v), 1'b0)) begin failures++; $display("[TB] FAIL rand_wrap_bcd[%0d] got=%h want=%h", v, bcdW, refBcd(int'(v), 1'b0)); end
            checks++; if (blankW !== refBlank(int'(v), 1'b0)) begin failures++; $display("[TB] FAIL rand_wrap_blank[%0d] got=%b want=%b", v, blankW, refBlank(int'(v), 1'b0)); end
            checks++; if (ovS !== (v > 16'd9999)) begin failures++; $display("[TB] FAIL rand_overflow[%0d] got=%b want=%b", v, ovS, (v > 16'd9999)); end
        end
    endtask

    task automatic test_back_to_back;
        int lat, rdy;
        logic [15:0] vals [54];
        logic [15:0] heldS, heldW;
        logic        wantDone;
        runConversion(16'd555, lat, rdy);
        heldS = refBcd(555, 1'b1);
        heldW = refBcd(555, 1'b0);
        for (int c = 0; c < 54; c++) vals[c] = 16'($urandom);
        in_valid = 1'b1;
        for (int c = 0; c < 54; c++) begin
            in_value = vals[c];
            @(posedge clock);
            @(negedge clock);
            wantDone = (c == 17) || (c == 35) || (c == 53);
            if (wantDone) begin
                heldS = refBcd(int'(vals[c - 17]), 1'b1);
                heldW = refBcd(int'(vals[c - 17]), 1'b0);
            end
            checks++; if (doneS !== wantDone) begin failures++; $display("[TB] FAIL b2b_done[c=%0d] got=%b want=%b", c, doneS, wantDone); end
            checks++; if (bcdS !== heldS) begin failures++; $display("[TB] FAIL b2b_sat_bcd[c=%0d] got=%h want=%h", c, bcdS, heldS); end
            checks++; if (bcdW !== heldW) begin failures++; $display("[TB] FAIL b2b_wrap_bcd[c=%0d] got=%h want=%h", c, bcdW, heldW); end
        end
        in_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        int lat, rdy, pulses;
        in_value = 16'd4321;
        in_valid = 1'b1;
        @(posedge clock);
        #2;
        in_valid = 1'b0;
        repeat (7) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (readyS !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_ready got=%b want=0", readyS); end
        checks++; if (bcdS !== 16'h0000) begin failures++; $display("[TB] FAIL mid_reset_bcd got=%h want=0000", bcdS); end
        checks++; if (blankS !== 4'b1110) begin failures++; $display("[TB] FAIL mid_reset_blank got=%b want=1110", blankS); end
        checks++; if (ovS !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_overflow got=%b want=0", ovS); end
        checks++; if (doneS !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_done got=%b want=0", doneS); end
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (doneS) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("[TB] FAIL mid_reset_no_done got=%0d pulses want=0", pulses); end
        checks++; if (readyS !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset_idle got=%b want=1", readyS); end
        runConversion(16'd42, lat, rdy);
        checks++; if (bcdS !== 16'h0042) begin failures++; $display("[TB] FAIL after_reset_bcd got=%h want=0042", bcdS); end
        checks++; if (blankS !== 4'b1100) begin failures++; $display("[TB] FAIL after_reset_blank got=%b want=1100", blankS); end
    endtask

    // Sequence of scenarios followed by the single summary line.
    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_value = 16'd0;
        test_reset();
        test_basic();
        test_leading_zeros();
        test_overflow();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so a stuck design cannot hang the run.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
